fifo_umbral: RTL

Synchronous first-word-fall-through FIFO with programmable almost-full / almost-empty thresholds. Four instances form the input buffers feeding the 4-port arbiter, and four more the output buffers it pushes into. The arbiter samples `data_out` combinationally in the same cycle it asserts `pop`, and throttles on `almost_full`. This block therefore provides zero-latency read data and registered-count status flags.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_mem.sv | 25 ++
 rtl/fifo_umbral.sv | 107 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO buffers and the 4-port arbiter that surrounds them:
// default geometry, destination-field position and default thresholds.
package fifo_pkg;

  localparam int FIFO_WORD_SIZE_DEF = 10;
  localparam int ADDR_WIDTH_DEF     = 3;

  // The two top bits of each word carry the destination port; the FIFO passes them through.
  localparam int DEST_MSB = FIFO_WORD_SIZE_DEF - 1;
  localparam int DEST_LSB = FIFO_WORD_SIZE_DEF - 2;

  localparam int UMBRAL_ALTO_DEF = 6;
  localparam int UMBRAL_BAJO_DEF = 2;

  // Accepted-operation encoding: {push accepted, pop accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_mem.sv
// Storage array for fifo_umbral: synchronous write, asynchronous read.
module fifo_mem #(
  parameter int FIFO_WORD_SIZE = 10,
  parameter int ADDR_WIDTH     = 3
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ADDR_WIDTH-1:0]     waddr,
  input  logic [FIFO_WORD_SIZE-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]     raddr,
  output logic [FIFO_WORD_SIZE-1:0] rdata
);

  logic [FIFO_WORD_SIZE-1:0] mem [2**ADDR_WIDTH];

  // Contents are never reset; the top level masks the read port while empty.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_umbral.sv
// First-word-fall-through FIFO with programmable almost-full / almost-empty thresholds.
// Optional sticky overflow/underflow flag enabled by defining FIFO_ERROR_EN.
module fifo_umbral
  import fifo_pkg::*;
#(
  parameter int FIFO_WORD_SIZE = FIFO_WORD_SIZE_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [FIFO_WORD_SIZE-1:0] data_in,
  input  logic [ADDR_WIDTH:0]       umbral_alto,
  input  logic [ADDR_WIDTH:0]       umbral_bajo,
  output logic [FIFO_WORD_SIZE-1:0] data_out,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      error,
  output logic [ADDR_WIDTH:0]       count
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0]     wr_ptr;
  logic [ADDR_WIDTH-1:0]     rd_ptr;
  logic [ADDR_WIDTH:0]       count_r;
  logic                      push_acc;
  logic                      pop_acc;
  fifo_op_e                  op;
  logic [FIFO_WORD_SIZE-1:0] rdata;

  function automatic logic [ADDR_WIDTH:0] next_count(input logic [ADDR_WIDTH:0] c,
                                                     input fifo_op_e         o);
    case (o)
      OP_PUSH: next_count = c + 1'b1;
      OP_POP:  next_count = c - 1'b1;
      default: next_count = c;
    endcase
  endfunction

  // A push into a full FIFO is only accepted when a pop frees the head slot in the same cycle;
  // a pop from an empty FIFO is never accepted, even alongside a push.
  assign push_acc = push && (!full || pop);
  assign pop_acc  = pop && !empty;
  assign op       = fifo_op_e'({push_acc, pop_acc});

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_r <= next_count(count_r, op);
    end
  end

  fifo_mem #(
    .FIFO_WORD_SIZE(FIFO_WORD_SIZE),
    .ADDR_WIDTH    (ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (push_acc && !reset),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  // Status is combinational from the registered count and the live threshold inputs.
  assign count        = count_r;
  assign empty        = (count_r == '0);
  assign full         = (count_r == DEPTH);
  assign almost_full  = (umbral_alto != '0) && (count_r >= umbral_alto);
  assign almost_empty = (count_r != '0) && (count_r <= umbral_bajo);
  assign data_out     = empty ? '0 : rdata;

`ifdef FIFO_ERROR_EN
  logic overflow;
  logic underflow;
  logic error_r;

  assign overflow  = push && full && !pop;
  assign underflow = pop && empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      error_r <= 1'b0;
    end else if (overflow || underflow) begin
      error_r <= 1'b1;
    end
  end

  assign error = error_r;
`else
  assign error = 1'b0;
`endif

endmodule
